mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported unified memory between the RV32I instruction-fetch path and the load/store path of the multicycle core. Handles arbitration, byte-lane mask generation, store-data lane shifting and load-data extraction with sign or zero extension per `load_f3_t` and `store_f3_t`. Rejects misaligned or undefined data accesses with an error response and never issues them to memory. Sits between the core's fetch/memory stages and the memory model, or the cache once one exists.

## Interface
- `FAIR`, default 1: 1 selects round-robin between fetch and data; 0 gives data fixed priority.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` in 1: fetch request; held high until `imem_ready`.
- `imem_addr` in 32: fetch address; bits [1:0] are ignored.
- `imem_ready` out 1: fetch request accepted this cycle.
- `imem_rvalid` out 1: one-cycle pulse; `imem_rdata` is valid.
- `imem_rdata` out 32: fetched instruction word.
- `dmem_req` in 1: data request; held high until `dmem_ready`.
- `dmem_we` in 1: 1 = store, 0 = load.
- `dmem_funct3` in 3: load or store funct3.
- `dmem_addr` in 32: byte address.
- `dmem_wdata` in 32: store data, right-aligned.
- `dmem_ready` out 1: data request accepted this cycle.
- `dmem_rvalid` out 1: one-cycle completion pulse, for loads and stores.
- `dmem_rdata` out 32: extended load data; 0 for stores and errors.
- `dmem_err` out 1: qualifies `dmem_rvalid`; access was rejected.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_rmask` out 4: read byte enables.
- `mem_wmask` out 4: write byte enables.
- `mem_wdata` out 32: lane-shifted store data.
- `mem_rdata` in 32: memory read word, valid with `mem_resp`.
- `mem_resp` in 1: memory completion, one cycle.

## Operation
- States:
  - IDLE: accepts requests.
  - BUSY_I: fetch outstanding.
  - BUSY_D: data access outstanding.
  - ERR: reject pending.
- IDLE acceptance:
  - `imem_ready`/`dmem_ready` are combinational from the requests.
  - At most one is asserted per cycle.
  - On acceptance, the address, mask, shifted data, funct3 and offset are latched.
- Arbitration when both request in IDLE:
  - FAIR=1: grant the requester not granted last. `last_grant` resets to data, so fetch wins the first tie.
  - FAIR=0: data always wins.
- Fetch: `mem_rmask`=1111, `mem_wmask`=0000.
- Load (`dmem_we`=0):
  - Byte accesses (lb/lbu): `rmask`=0001<<off.
  - Halfword accesses (lh/lhu): `rmask`=0011<<off.
  - lw: `rmask`=1111.
  - `wmask`=0.
  - `off` = `dmem_addr[1:0]`.
- Store: `wmask` uses the same pattern by sb/sh/sw; `rmask`=0; `mem_wdata` = `dmem_wdata << (8*off)`.
- Load return:
  - Select the byte or halfword at `off`.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Reject conditions:
  - halfword access with `off[0]`=1;
  - word access with `off`≠0;
  - load funct3 ∈ {011, 110, 111};
  - store funct3 > 010.
- On reject: the request is accepted and the arbiter goes to ERR for one cycle. Memory outputs stay idle.
- Idle memory outputs: while not in BUSY_*, `mem_addr`, both masks and `mem_wdata` are all 0.
- `mem_resp` in IDLE or ERR is ignored.

## Timing
- Fetch or valid data access, accepted in cycle 0:
  - `mem_*` are registered and driven from cycle 1 through cycle k, where `mem_resp`=1 in cycle k (k≥1).
  - `mem_rdata` is captured at k.
  - `*_rvalid` is asserted in cycle k+1; the FSM is back in IDLE in k+1.
  - A new request can be accepted in k+1, in the same cycle as `rvalid`.
- Rejected data access, accepted in cycle 0: `dmem_rvalid`=`dmem_err`=1 in cycle 2 with `dmem_rdata`=0. The FSM is in ERR during cycle 1 and in IDLE in cycle 2.
- Minimum valid round trip: 2 cycles (`mem_resp` in cycle 1).
- Requester inputs may change after `ready`; all latched values are used.
- Reset, asserted asynchronously at any time:
  - State goes to IDLE and `last_grant` to data.
  - All outputs go to 0.
  - An in-flight access is dropped without `rvalid`.
  - A stale `mem_resp` after reset is ignored.

## Test plan
- Fetch at 0x0000_1006, `mem_resp` 3 cycles after drive, `mem_rdata`=0x0000_0013 → `mem_addr`=0x0000_1004, `rmask`=1111, `imem_rvalid` with 0x0000_0013 one cycle after resp.
- lb then lbu at 0x103 with `mem_rdata`=0x80FF_0000 → `rmask`=1000 for both; results 0xFFFF_FF80 and 0x0000_0080.
- sh at 0x202 with `dmem_wdata`=0x1234_ABCD → `wmask`=1100, `mem_wdata`=0xABCD_0000; then `dmem_rvalid`=1, `err`=0, `rdata`=0.
- lw at 0x301 and store funct3=011 → no `mem_*` activity; `dmem_rvalid`+`dmem_err` two cycles after each acceptance.
- Simultaneous requests held for 4 transactions with FAIR=1 → grants I,D,I,D. With FAIR=0 → all D until `dmem_req` drops.
- `rst_n` pulsed low during BUSY_D, with `mem_resp` arriving after release → no `rvalid`; all outputs 0; next tie grants fetch.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and memory.
// The arbiter takes the slave view; the core-plus-memory side takes the master view.
interface mem_port_arbiter_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        dmem_req;
  logic        dmem_we;
  logic [2:0]  dmem_funct3;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        dmem_err;

  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  dmem_req, dmem_we, dmem_funct3, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rvalid, dmem_rdata, dmem_err,
    output mem_addr, mem_rmask, mem_wmask, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output dmem_req, dmem_we, dmem_funct3, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rvalid, dmem_rdata, dmem_err,
    input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-ported memory,
// generating byte lanes, shifting store data and extending load data.
module mem_port_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ERR} state_t;

  state_t      state;
  logic        last_grant_d;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        we_q;

  logic        grant_i, grant_d;
  logic [1:0]  d_off;
  logic [3:0]  d_mask;
  logic        d_bad;
  logic [31:0] d_wdata;
  logic [31:0] ld_shift, ld_data;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst_n && state == IDLE) begin
      if (bus.imem_req && (!bus.dmem_req || (FAIR && last_grant_d)))
        grant_i = 1'b1;
      else if (bus.dmem_req)
        grant_d = 1'b1;
    end
  end

  assign bus.imem_ready = grant_i;
  assign bus.dmem_ready = grant_d;

  always_comb begin
    d_off = bus.dmem_addr[1:0];
    case (bus.dmem_funct3[1:0])
      2'b00:   d_mask = 4'b0001 << d_off;
      2'b01:   d_mask = 4'b0011 << d_off;
      default: d_mask = 4'b1111;
    endcase
    d_bad = 1'b0;
    if (bus.dmem_funct3[1:0] == 2'b01 && d_off[0]) d_bad = 1'b1;
    if (bus.dmem_funct3[1:0] == 2'b10 && d_off != 2'b00) d_bad = 1'b1;
    if (bus.dmem_we) begin
      if (bus.dmem_funct3 > 3'b010) d_bad = 1'b1;
    end else if (bus.dmem_funct3[1:0] == 2'b11 || bus.dmem_funct3 == 3'b110) begin
      d_bad = 1'b1;
    end
    d_wdata = bus.dmem_wdata << {d_off, 3'b000};
  end

  always_comb begin
    ld_shift = bus.mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'h0, ld_shift[7:0]};
      3'b101:  ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant_d    <= 1'b1;
      f3_q            <= '0;
      off_q           <= '0;
      we_q            <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_rmask   <= '0;
      bus.mem_wmask   <= '0;
      bus.mem_wdata   <= '0;
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= '0;
      bus.dmem_rvalid <= 1'b0;
      bus.dmem_rdata  <= '0;
      bus.dmem_err    <= 1'b0;
    end else begin
      bus.imem_rvalid <= 1'b0;
      bus.dmem_rvalid <= 1'b0;
      bus.dmem_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i) begin
            state         <= BUSY_I;
            last_grant_d  <= 1'b0;
            bus.mem_addr  <= {bus.imem_addr[31:2], 2'b00};
            bus.mem_rmask <= 4'b1111;
            bus.mem_wmask <= '0;
            bus.mem_wdata <= '0;
          end else if (grant_d) begin
            last_grant_d <= 1'b1;
            f3_q         <= bus.dmem_funct3;
            off_q        <= d_off;
            we_q         <= bus.dmem_we;
            // Rejected accesses park in ERR and leave the memory bus idle.
            if (d_bad) begin
              state <= ERR;
            end else begin
              state         <= BUSY_D;
              bus.mem_addr  <= {bus.dmem_addr[31:2], 2'b00};
              bus.mem_rmask <= bus.dmem_we ? 4'b0000 : d_mask;
              bus.mem_wmask <= bus.dmem_we ? d_mask : 4'b0000;
              bus.mem_wdata <= bus.dmem_we ? d_wdata : 32'h0;
            end
          end
        end
        BUSY_I: begin
          if (bus.mem_resp) begin
            state           <= IDLE;
            bus.imem_rvalid <= 1'b1;
            bus.imem_rdata  <= bus.mem_rdata;
            bus.mem_addr    <= '0;
            bus.mem_rmask   <= '0;
            bus.mem_wmask   <= '0;
            bus.mem_wdata   <= '0;
          end
        end
        BUSY_D: begin
          if (bus.mem_resp) begin
            state           <= IDLE;
            bus.dmem_rvalid <= 1'b1;
            bus.dmem_rdata  <= we_q ? 32'h0 : ld_data;
            bus.mem_addr    <= '0;
            bus.mem_rmask   <= '0;
            bus.mem_wmask   <= '0;
            bus.mem_wdata   <= '0;
          end
        end
        ERR: begin
          state           <= IDLE;
          bus.dmem_rvalid <= 1'b1;
          bus.dmem_err    <= 1'b1;
          bus.dmem_rdata  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a byte-level access model;
// a FAIR=1 and a FAIR=0 instance see identical stimulus.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req = 1'b0;
  logic [31:0] imem_addr = '0;
  logic        dmem_req = 1'b0, dmem_we = 1'b0;
  logic [2:0]  dmem_funct3 = '0;
  logic [31:0] dmem_addr = '0, dmem_wdata = '0, mem_rdata = '0;
  logic        mem_resp = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  mem_port_arbiter_if if1();
  mem_port_arbiter_if if0();

  assign if1.imem_req = imem_req;       assign if0.imem_req = imem_req;
  assign if1.imem_addr = imem_addr;     assign if0.imem_addr = imem_addr;
  assign if1.dmem_req = dmem_req;       assign if0.dmem_req = dmem_req;
  assign if1.dmem_we = dmem_we;         assign if0.dmem_we = dmem_we;
  assign if1.dmem_funct3 = dmem_funct3; assign if0.dmem_funct3 = dmem_funct3;
  assign if1.dmem_addr = dmem_addr;     assign if0.dmem_addr = dmem_addr;
  assign if1.dmem_wdata = dmem_wdata;   assign if0.dmem_wdata = dmem_wdata;
  assign if1.mem_rdata = mem_rdata;     assign if0.mem_rdata = mem_rdata;
  assign if1.mem_resp = mem_resp;       assign if0.mem_resp = mem_resp;

  mem_port_arbiter #(.FAIR(1'b1)) dut_fair (.clk(clk), .rst_n(rst_n), .bus(if1));
  mem_port_arbiter #(.FAIR(1'b0)) dut_prio (.clk(clk), .rst_n(rst_n), .bus(if0));

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic fetch_xact(input logic [31:0] addr, input logic [31:0] rd, input int unsigned lat);
    @(negedge clk);
    imem_req = 1'b1; imem_addr = addr; dmem_req = 1'b0;
    #1;
    n_checks++; if (if1.imem_ready !== 1'b1) $display("FAIL fetch_ready: got %b want 1", if1.imem_ready); else n_pass++;
    n_checks++; if (if1.dmem_ready !== 1'b0) $display("FAIL fetch_dready: got %b want 0", if1.dmem_ready); else n_pass++;
    @(negedge clk);
    imem_req = 1'b0; imem_addr = $urandom;
    for (int unsigned c = 1; c <= lat; c++) begin
      #1;
      n_checks++; if (if1.mem_addr !== {addr[31:2], 2'b00}) $display("FAIL fetch_addr: got %h want %h", if1.mem_addr, {addr[31:2], 2'b00}); else n_pass++;
      n_checks++; if ({if1.mem_rmask, if1.mem_wmask} !== 8'hF0) $display("FAIL fetch_masks: got %h want f0", {if1.mem_rmask, if1.mem_wmask}); else n_pass++;
      n_checks++; if (if1.imem_rvalid !== 1'b0) $display("FAIL fetch_early_rvalid: got %b want 0", if1.imem_rvalid); else n_pass++;
      if (c == lat) begin mem_resp = 1'b1; mem_rdata = rd; end
      @(negedge clk);
      mem_resp = 1'b0; mem_rdata = $urandom;
    end
    #1;
    n_checks++; if (if1.imem_rvalid !== 1'b1) $display("FAIL fetch_rvalid: got %b want 1", if1.imem_rvalid); else n_pass++;
    n_checks++; if (if1.imem_rdata !== rd) $display("FAIL fetch_rdata: got %h want %h", if1.imem_rdata, rd); else n_pass++;
    n_checks++; if ({if1.mem_addr, if1.mem_rmask} !== 36'h0) $display("FAIL fetch_idle_bus: got %h want 0", {if1.mem_addr, if1.mem_rmask}); else n_pass++;
  endtask

  task automatic data_xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int unsigned lat);
    int unsigned off, size;
    logic bad;
    logic [3:0] mask;
    logic [31:0] exp_wd, exp_rd;
    logic [63:0] w;
    off  = int'(addr[1:0]);
    size = 1 << f3[1:0];
    bad  = (off % size) != 0;
    if (we) bad = bad || (f3 > 3'd2);
    else    bad = bad || (f3[1:0] == 2'd3) || (f3 == 3'd6);
    mask   = 4'(((1 << size) - 1) << off);
    exp_wd = wd << (8 * off);
    w = {32'h0, rd} >> (8 * off);
    if (size < 4) begin
      w = w % (64'd1 << (8 * size));
      if (!f3[2] && w >= (64'd1 << (8 * size - 1))) w = w + (64'd1 << 32) - (64'd1 << (8 * size));
    end
    exp_rd = we ? 32'h0 : w[31:0];

    @(negedge clk);
    dmem_req = 1'b1; dmem_we = we; dmem_funct3 = f3; dmem_addr = addr; dmem_wdata = wd; imem_req = 1'b0;
    #1;
    n_checks++; if (if1.dmem_ready !== 1'b1) $display("FAIL data_ready: got %b want 1", if1.dmem_ready); else n_pass++;
    @(negedge clk);
    dmem_req = 1'b0; dmem_addr = $urandom; dmem_wdata = $urandom; dmem_funct3 = 3'($urandom); dmem_we = 1'($urandom);
    if (bad) begin
      #1;
      n_checks++; if ({if1.mem_addr, if1.mem_rmask, if1.mem_wmask, if1.mem_wdata} !== 72'h0) $display("FAIL err_bus_idle: got %h want 0", {if1.mem_addr, if1.mem_rmask, if1.mem_wmask, if1.mem_wdata}); else n_pass++;
      n_checks++; if (if1.dmem_rvalid !== 1'b0) $display("FAIL err_early_rvalid: got %b want 0", if1.dmem_rvalid); else n_pass++;
      @(negedge clk);
      #1;
      n_checks++; if ({if1.dmem_rvalid, if1.dmem_err, if1.dmem_rdata} !== 34'h3_0000_0000) $display("FAIL err_response: got %h want 300000000", {if1.dmem_rvalid, if1.dmem_err, if1.dmem_rdata}); else n_pass++;
    end else begin
      for (int unsigned c = 1; c <= lat; c++) begin
        #1;
        n_checks++; if (if1.mem_addr !== {addr[31:2], 2'b00}) $display("FAIL data_addr: got %h want %h", if1.mem_addr, {addr[31:2], 2'b00}); else n_pass++;
        n_checks++; if (if1.mem_rmask !== (we ? 4'h0 : mask)) $display("FAIL data_rmask: got %b want %b", if1.mem_rmask, we ? 4'h0 : mask); else n_pass++;
        n_checks++; if (if1.mem_wmask !== (we ? mask : 4'h0)) $display("FAIL data_wmask: got %b want %b", if1.mem_wmask, we ? mask : 4'h0); else n_pass++;
        if (we) begin
          n_checks++; if (if1.mem_wdata !== exp_wd) $display("FAIL data_wdata: got %h want %h", if1.mem_wdata, exp_wd); else n_pass++;
        end
        if (c == lat) begin mem_resp = 1'b1; mem_rdata = rd; end
        @(negedge clk);
        mem_resp = 1'b0; mem_rdata = $urandom;
      end
      #1;
      n_checks++; if ({if1.dmem_rvalid, if1.dmem_err} !== 2'b10) $display("FAIL data_rvalid_err: got %b want 10", {if1.dmem_rvalid, if1.dmem_err}); else n_pass++;
      n_checks++; if (if1.dmem_rdata !== exp_rd) $display("FAIL data_rdata: got %h want %h", if1.dmem_rdata, exp_rd); else n_pass++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_req = 1'b0; dmem_req = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if ({if1.imem_ready, if1.imem_rvalid, if1.imem_rdata, if1.dmem_ready, if1.dmem_rvalid, if1.dmem_rdata, if1.dmem_err} !== 68'h0) $display("FAIL reset_core_outputs: got nonzero want 0"); else n_pass++;
    n_checks++; if ({if1.mem_addr, if1.mem_rmask, if1.mem_wmask, if1.mem_wdata} !== 72'h0) $display("FAIL reset_mem_outputs: got %h want 0", {if1.mem_addr, if1.mem_rmask, if1.mem_wmask, if1.mem_wdata}); else n_pass++;
  endtask

  task automatic test_fetch();
    fetch_xact(32'h0000_1006, 32'h0000_0013, 3);
    for (int i = 0; i < 6; i++) fetch_xact($urandom, $urandom, $urandom_range(1, 3));
  endtask

  task automatic test_loads();
    data_xact(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1);
    data_xact(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 2);
    for (int i = 0; i < 24; i++) data_xact(1'b0, 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(1, 3));
  endtask

  task automatic test_stores();
    data_xact(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, $urandom, 2);
    for (int i = 0; i < 24; i++) data_xact(1'b1, 3'($urandom_range(0, 4)), $urandom, $urandom, $urandom, $urandom_range(1, 3));
  endtask

  task automatic test_reject();
    data_xact(1'b0, 3'b010, 32'h0000_0301, 32'h0, $urandom, 1);
    data_xact(1'b1, 3'b011, 32'h0000_0400, $urandom, $urandom, 1);
  endtask

  task automatic test_arbitration();
    bit g1[$], g0[$];
    bit seen;
    do_reset();
    imem_req = 1'b1; imem_addr = 32'h0000_0800;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_funct3 = 3'b010; dmem_addr = 32'h0000_0400;
    mem_resp = 1'b1;
    for (int c = 0; c < 40 && (g1.size() < 4 || g0.size() < 4); c++) begin
      #1;
      if (if1.imem_ready) g1.push_back(1'b0);
      if (if1.dmem_ready) g1.push_back(1'b1);
      if (if0.imem_ready) g0.push_back(1'b0);
      if (if0.dmem_ready) g0.push_back(1'b1);
      @(negedge clk);
      mem_rdata = $urandom;
    end
    n_checks++; if (g1.size() < 4 || g0.size() < 4) $display("FAIL arb_grant_count: got %0d/%0d want 4/4", g1.size(), g0.size()); else n_pass++;
    for (int i = 0; i < 4 && i < g1.size() && i < g0.size(); i++) begin
      n_checks++; if (g1[i] !== 1'(i % 2)) $display("FAIL arb_fair_grant%0d: got %b want %b (1=data)", i, g1[i], 1'(i % 2)); else n_pass++;
      n_checks++; if (g0[i] !== 1'b1) $display("FAIL arb_prio_grant%0d: got %b want 1 (1=data)", i, g0[i]); else n_pass++;
    end
    dmem_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      #1;
      seen = if0.imem_ready;
      @(negedge clk);
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL arb_prio_fetch_after_drop: got %b want 1", seen); else n_pass++;
    imem_req = 1'b0;
    repeat (3) @(negedge clk);
    mem_resp = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_funct3 = 3'b010; dmem_addr = 32'h0000_0500; imem_req = 1'b0;
    @(negedge clk);
    dmem_req = 1'b0;
    #1;
    n_checks++; if (if1.mem_rmask !== 4'hF) $display("FAIL rst_inflight_rmask: got %b want 1111", if1.mem_rmask); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({if1.mem_addr, if1.mem_rmask, if1.mem_wmask, if1.mem_wdata} !== 72'h0) $display("FAIL rst_async_mem: got %h want 0", {if1.mem_addr, if1.mem_rmask, if1.mem_wmask, if1.mem_wdata}); else n_pass++;
    n_checks++; if ({if1.imem_rvalid, if1.imem_rdata, if1.dmem_rvalid, if1.dmem_rdata, if1.dmem_err} !== 67'h0) $display("FAIL rst_async_core: got nonzero want 0"); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if ({if1.dmem_rvalid, if1.imem_rvalid, if1.mem_rmask} !== 6'h0) $display("FAIL rst_stale_resp%0d: got %h want 0", c, {if1.dmem_rvalid, if1.imem_rvalid, if1.mem_rmask}); else n_pass++;
      @(negedge clk);
      mem_resp = 1'b0;
    end
    imem_req = 1'b1; dmem_req = 1'b1; dmem_funct3 = 3'b010; dmem_addr = 32'h0;
    #1;
    n_checks++; if ({if1.imem_ready, if1.dmem_ready} !== 2'b10) $display("FAIL rst_first_tie: got %b want 10", {if1.imem_ready, if1.dmem_ready}); else n_pass++;
    @(negedge clk);
    imem_req = 1'b0; dmem_req = 1'b0; mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_loads();
    test_stores();
    test_reject();
    test_arbitration();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
